// File: rtl/transmissor_jogo_uart_pkg.sv
// Shared definitions for the game-status UART transmitter: ASCII constants,
// sequencer/serializer state codes and the hex-to-ASCII helper.
package transmissor_jogo_uart_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_A     = 8'h41;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam int         TAM_PACOTE  = 6;
    localparam logic [2:0] ULTIMO_BYTE = 3'(TAM_PACOTE - 1);

    typedef enum logic [3:0] {
        INICIAL   = 4'd0,
        ESPERA    = 4'd1,
        CARREGA   = 4'd2,
        TRANSMITE = 4'd3,
        PROXIMO   = 4'd4,
        FIM       = 4'd5
    } seq_estado_t;

    typedef enum logic {
        REPOUSO = 1'b0,
        DADOS   = 1'b1
    } tx_estado_t;

    function automatic logic [7:0] hex_ascii(input logic [3:0] valor);
        logic [7:0] r;
        if (valor < 4'd10) begin
            r = ASCII_ZERO + {4'd0, valor};
        end else begin
            r = ASCII_A + {4'd0, valor - 4'd10};
        end
        return r;
    endfunction

endpackage

// File: rtl/transmissor_jogo_uart_tx_byte.sv
// UART 8N1 byte serializer: start, 8 data bits LSB first, stop; BAUD_DIV
// cycles per bit, line output registered one cycle behind the shift register.
module uart_tx_byte
    import transmissor_jogo_uart_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       partida,
    input  logic [7:0] dado,
    output logic       serial,
    output logic       ocupado_byte,
    output logic       fim_byte
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    tx_estado_t      estado_r;
    logic [9:0]      shift_r;
    logic [CW-1:0]   baud_cnt_r;
    logic [3:0]      bit_cnt_r;
    logic            serial_r;
    logic            baud_fim_s;

    // End-of-bit and end-of-byte decode; done fires in the last cycle of the stop bit
    always_comb begin
        baud_fim_s = (baud_cnt_r == CW'(BAUD_DIV - 1));
        if ((estado_r == DADOS) && baud_fim_s && (bit_cnt_r == 4'd9)) begin
            fim_byte = 1'b1;
        end else begin
            fim_byte = 1'b0;
        end
    end

    // Baud/bit counters, frame shift register and registered line driver
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_r   <= REPOUSO;
            shift_r    <= 10'h3FF;
            baud_cnt_r <= '0;
            bit_cnt_r  <= 4'd0;
            serial_r   <= 1'b1;
        end else begin
            case (estado_r)
                REPOUSO: begin
                    serial_r <= 1'b1;
                    if (partida) begin
                        shift_r    <= {1'b1, dado, 1'b0};
                        baud_cnt_r <= '0;
                        bit_cnt_r  <= 4'd0;
                        estado_r   <= DADOS;
                    end
                end
                DADOS: begin
                    serial_r <= shift_r[0];
                    if (baud_fim_s) begin
                        baud_cnt_r <= '0;
                        shift_r    <= {1'b1, shift_r[9:1]};
                        if (bit_cnt_r == 4'd9) begin
                            bit_cnt_r <= 4'd0;
                            estado_r  <= REPOUSO;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CW'(1);
                    end
                end
                default: begin
                    estado_r <= REPOUSO;
                    serial_r <= 1'b1;
                end
            endcase
        end
    end

    assign serial       = serial_r;
    assign ocupado_byte = (estado_r == DADOS);

endmodule

// File: rtl/transmissor_jogo_uart.sv
// Game status transmitter: snapshots the game fields and sends them as a
// 6-byte ASCII packet over UART whenever they change, on request, and after reset.
module transmissor_jogo_uart
    import transmissor_jogo_uart_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] macro,
    input  logic [3:0] micro,
    input  logic [3:0] estado,
    input  logic [1:0] resultado_macro,
    input  logic [1:0] resultado_jogo,
    input  logic       enviar,
    output logic       saida_serial,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);

    seq_estado_t estado_r, proximo_s;
    logic [15:0] snapshot_r;
    logic [15:0] entrada_s;
    logic        inicial_r;
    logic [2:0]  indice_r;
    logic        ocupado_r;
    logic        pronto_r;
    logic        gatilho_s;
    logic        partida_s;
    logic [7:0]  dado_s;
    logic        ocupado_byte_s;
    logic        fim_byte_s;

    assign entrada_s = {macro, micro, estado, resultado_macro, resultado_jogo};

    // Trigger, next-state and serializer start
    always_comb begin
        gatilho_s = (entrada_s != snapshot_r) || enviar || inicial_r;
        proximo_s = estado_r;
        partida_s = 1'b0;
        case (estado_r)
            INICIAL: proximo_s = ESPERA;
            ESPERA: begin
                if (gatilho_s) proximo_s = CARREGA;
                else           proximo_s = ESPERA;
            end
            CARREGA: begin
                if (!ocupado_byte_s) begin
                    partida_s = 1'b1;
                    proximo_s = TRANSMITE;
                end else begin
                    proximo_s = CARREGA;
                end
            end
            TRANSMITE: begin
                if (fim_byte_s) proximo_s = PROXIMO;
                else            proximo_s = TRANSMITE;
            end
            PROXIMO: begin
                if (indice_r == ULTIMO_BYTE) proximo_s = FIM;
                else                         proximo_s = CARREGA;
            end
            FIM:     proximo_s = ESPERA;
            default: proximo_s = INICIAL;
        endcase
    end

    // Byte mux: every field byte comes from the latched snapshot, never the live inputs
    always_comb begin
        dado_s = ASCII_LF;
        case (indice_r)
            3'd0:    dado_s = hex_ascii(snapshot_r[15:12]);
            3'd1:    dado_s = hex_ascii(snapshot_r[11:8]);
            3'd2:    dado_s = hex_ascii(snapshot_r[7:4]);
            3'd3:    dado_s = ASCII_ZERO + {6'd0, snapshot_r[3:2]};
            3'd4:    dado_s = ASCII_ZERO + {6'd0, snapshot_r[1:0]};
            default: dado_s = ASCII_LF;
        endcase
    end

    // Sequencer state, snapshot, byte index and registered status outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_r   <= INICIAL;
            snapshot_r <= 16'd0;
            inicial_r  <= 1'b1;
            indice_r   <= 3'd0;
            ocupado_r  <= 1'b0;
            pronto_r   <= 1'b0;
        end else begin
            estado_r  <= proximo_s;
            pronto_r  <= (proximo_s == FIM);
            // busy spans first start bit to the edge entering FIM
            ocupado_r <= (estado_r != ESPERA) &&
                         (proximo_s inside {CARREGA, TRANSMITE, PROXIMO});
            if ((estado_r == ESPERA) && gatilho_s) begin
                snapshot_r <= entrada_s;
                inicial_r  <= 1'b0;
                indice_r   <= 3'd0;
            end else if ((estado_r == PROXIMO) && (indice_r != ULTIMO_BYTE)) begin
                indice_r <= indice_r + 3'd1;
            end
        end
    end

    uart_tx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx_byte (
        .clock        (clock),
        .reset        (reset),
        .partida      (partida_s),
        .dado         (dado_s),
        .serial       (saida_serial),
        .ocupado_byte (ocupado_byte_s),
        .fim_byte     (fim_byte_s)
    );

    assign ocupado   = ocupado_r;
    assign pronto    = pronto_r;
    assign db_estado = 4'(estado_r);

endmodule

// File: tb/tb_transmissor_jogo_uart.sv
// Self-checking bench: a reference UART receiver decodes the line and packets
// are compared against bytes computed from the field values driven.
module tb_transmissor_jogo_uart;

    localparam int BD = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] macro, micro, estado;
    logic [1:0] resultado_macro, resultado_jogo;
    logic       enviar;
    logic       saida_serial, ocupado, pronto;
    logic [3:0] db_estado;

    int testes = 0;
    int falhas = 0;
    int cyc = 0;

    logic [7:0] rx_q[$];
    int         rx_t[$];
    int         rx_inic = 0;
    int         frame_err = 0;
    int         shape_err = 0;

    transmissor_jogo_uart #(.BAUD_DIV(BD)) dut (
        .clock           (clock),
        .reset           (reset),
        .macro           (macro),
        .micro           (micro),
        .estado          (estado),
        .resultado_macro (resultado_macro),
        .resultado_jogo  (resultado_jogo),
        .enviar          (enviar),
        .saida_serial    (saida_serial),
        .ocupado         (ocupado),
        .pronto          (pronto),
        .db_estado       (db_estado)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Reference receiver: samples every cycle, each byte is 10*BD samples
    initial begin : receptor
        logic ant;
        logic amostras [0:10*BD-1];
        logic bitv;
        logic [7:0] d;
        int t0;
        bit aborta;
        ant = 1'b1;
        forever begin
            @(negedge clock);
            if (!reset && ant && !saida_serial) begin
                t0 = cyc;
                aborta = 1'b0;
                rx_inic++;
                amostras[0] = saida_serial;
                for (int n = 1; n < 10*BD; n++) begin
                    @(negedge clock);
                    if (reset) begin
                        aborta = 1'b1;
                        break;
                    end
                    amostras[n] = saida_serial;
                end
                if (!aborta) begin
                    d = 8'h00;
                    for (int j = 0; j < 10; j++) begin
                        bitv = amostras[j*BD + BD/2];
                        for (int k = 0; k < BD; k++)
                            if (amostras[j*BD + k] !== bitv) shape_err++;
                        if (j >= 1 && j <= 8) d[j-1] = bitv;
                    end
                    if (amostras[9*BD + BD/2] !== 1'b1) frame_err++;
                    rx_q.push_back(d);
                    rx_t.push_back(t0);
                    ant = amostras[10*BD-1];
                end else begin
                    ant = 1'b1;
                end
            end else begin
                ant = reset ? 1'b1 : saida_serial;
            end
        end
    end

    function automatic logic [7:0] hexa(input logic [3:0] v);
        int c;
        c = (v < 4'd10) ? (48 + int'(v)) : (55 + int'(v));
        return 8'(c);
    endfunction

    function automatic logic [47:0] pacote(input logic [15:0] v);
        return {hexa(v[15:12]), hexa(v[11:8]), hexa(v[7:4]),
                8'(48 + int'(v[3:2])), 8'(48 + int'(v[1:0])), 8'd10};
    endfunction

    function automatic logic [47:0] recebido();
        logic [47:0] r;
        r = 'x;
        for (int i = 0; i < 6; i++)
            if (i < rx_q.size()) r[47-8*i -: 8] = rx_q[i];
        return r;
    endfunction

    function automatic int max_gap();
        int m;
        m = 0;
        for (int i = 1; i < rx_t.size(); i++)
            if (rx_t[i] - rx_t[i-1] > m) m = rx_t[i] - rx_t[i-1];
        return m;
    endfunction

    task automatic limpa();
        rx_q.delete();
        rx_t.delete();
    endtask

    task automatic aplica(input logic [15:0] v);
        {macro, micro, estado, resultado_macro, resultado_jogo} = v;
    endtask

    task automatic espera_pronto(input int limite, output int t);
        t = -1;
        for (int i = 0; i < limite; i++) begin
            @(negedge clock);
            if (pronto) begin
                t = cyc;
                break;
            end
        end
    endtask

    task automatic conta_pronto(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (pronto) c++;
        end
    endtask

    task automatic test_reset();
        int t, tk, ruido;
        reset = 1'b1;
        enviar = 1'b0;
        aplica(16'h0000);
        repeat (3) @(negedge clock);
        testes++;
        if ({saida_serial, ocupado, pronto, db_estado} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
            falhas++;
            $display("FAIL reset_state got line/busy/pronto/db=%b%b%b/%0d want 100/0",
                     saida_serial, ocupado, pronto, db_estado);
        end
        limpa();
        reset = 1'b0;
        @(negedge clock);
        testes++;
        if (db_estado !== 4'd1) begin
            falhas++; $display("FAIL reset_espera got db=%0d want 1", db_estado);
        end
        @(negedge clock);
        tk = cyc;
        testes++;
        if ({db_estado, ocupado} !== {4'd2, 1'b0}) begin
            falhas++; $display("FAIL reset_carrega got db=%0d busy=%b want 2/0", db_estado, ocupado);
        end
        @(negedge clock);
        testes++;
        if ({db_estado, ocupado, saida_serial} !== {4'd3, 1'b1, 1'b1}) begin
            falhas++;
            $display("FAIL reset_transmite got db=%0d busy=%b line=%b want 3/1/1",
                     db_estado, ocupado, saida_serial);
        end
        @(negedge clock);
        testes++;
        if (saida_serial !== 1'b0) begin
            falhas++; $display("FAIL reset_start_bit got line=%b want 0", saida_serial);
        end
        espera_pronto(60*BD + 40, t);
        testes++;
        if (t < 0 || (t - tk) > 60*BD + 12 || ocupado !== 1'b0) begin
            falhas++;
            $display("FAIL reset_pronto got delay=%0d busy=%b want <=%0d/0", t - tk, ocupado, 60*BD + 12);
        end
        @(negedge clock);
        testes++;
        if (pronto !== 1'b0) begin
            falhas++; $display("FAIL reset_pronto_width got pronto=%b want 0", pronto);
        end
        @(negedge clock);
        testes++;
        if (rx_q.size() != 6 || recebido() !== pacote(16'h0000)) begin
            falhas++;
            $display("FAIL reset_packet got %h (n=%0d) want %h", recebido(), rx_q.size(), pacote(16'h0000));
        end
        testes++;
        if (max_gap() > 10*BD + 2) begin
            falhas++; $display("FAIL reset_gap got %0d want <=%0d", max_gap(), 10*BD + 2);
        end
        ruido = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (!saida_serial || pronto || db_estado != 4'd1) ruido++;
        end
        testes++;
        if (ruido != 0) begin
            falhas++; $display("FAIL reset_idle got %0d bad cycles want 0", ruido);
        end
    endtask

    task automatic test_campos();
        int t;
        logic [15:0] v;
        v = {4'h4, 4'hB, 4'hC, 2'd1, 2'd3};
        limpa();
        aplica(v);
        espera_pronto(60*BD + 40, t);
        repeat (2) @(negedge clock);
        testes++;
        if (t < 0 || rx_q.size() != 6 || recebido() !== 48'h3442_4331_330A) begin
            falhas++;
            $display("FAIL campos_packet got %h (n=%0d) want %h", recebido(), rx_q.size(), 48'h3442_4331_330A);
        end
        testes++;
        if (recebido() !== pacote(v)) begin
            falhas++; $display("FAIL campos_model got %h want %h", recebido(), pacote(v));
        end
        testes++;
        if (max_gap() > 10*BD + 2 || shape_err != 0) begin
            falhas++; $display("FAIL campos_timing got gap=%0d shape=%0d want <=%0d/0", max_gap(), shape_err, 10*BD + 2);
        end
    endtask

    task automatic test_enviar();
        int c;
        limpa();
        @(negedge clock);
        enviar = 1'b1;
        @(negedge clock);
        enviar = 1'b0;
        conta_pronto(60*BD + 112, c);
        testes++;
        if (c != 1 || recebido() !== pacote({4'h4, 4'hB, 4'hC, 2'd1, 2'd3}) || rx_q.size() != 6) begin
            falhas++;
            $display("FAIL enviar_idle got pronto=%0d pkt=%h n=%0d want 1/%h/6", c, recebido(), rx_q.size(),
                     pacote({4'h4, 4'hB, 4'hC, 2'd1, 2'd3}));
        end
        enviar = 1'b1;
        @(negedge clock);
        enviar = 1'b0;
        repeat (20) @(negedge clock);
        enviar = 1'b1;
        @(negedge clock);
        enviar = 1'b0;
        conta_pronto(60*BD + 112, c);
        testes++;
        if (c != 1) begin
            falhas++; $display("FAIL enviar_busy got %0d packets want 1", c);
        end
    endtask

    task automatic test_mudanca();
        int t, base, achou;
        limpa();
        base = rx_inic;
        aplica({4'h4, 4'h5, 4'hC, 2'd1, 2'd3});
        for (int i = 0; i < 40*BD && rx_inic < base + 2; i++) @(negedge clock);
        repeat (BD) @(negedge clock);
        aplica({4'h4, 4'h7, 4'hC, 2'd1, 2'd3});
        espera_pronto(60*BD + 40, t);
        achou = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            if (db_estado == 4'd2) achou = 1;
        end
        testes++;
        if (t < 0 || achou != 1) begin
            falhas++; $display("FAIL mudanca_restart got pronto_t=%0d carrega=%0d want restart<=2", t, achou);
        end
        testes++;
        if (rx_q.size() != 6 || recebido() !== pacote({4'h4, 4'h5, 4'hC, 2'd1, 2'd3})) begin
            falhas++;
            $display("FAIL mudanca_first got %h want %h", recebido(), pacote({4'h4, 4'h5, 4'hC, 2'd1, 2'd3}));
        end
        limpa();
        espera_pronto(60*BD + 40, t);
        repeat (2) @(negedge clock);
        testes++;
        if (t < 0 || rx_q.size() != 6 || recebido() !== pacote({4'h4, 4'h7, 4'hC, 2'd1, 2'd3})) begin
            falhas++;
            $display("FAIL mudanca_second got %h want %h", recebido(), pacote({4'h4, 4'h7, 4'hC, 2'd1, 2'd3}));
        end
    endtask

    task automatic test_reset_meio();
        int t, base;
        logic [15:0] v;
        v = {4'h8, 4'h2, 4'h3, 2'd2, 2'd0};
        limpa();
        base = rx_inic;
        aplica(v);
        for (int i = 0; i < 40*BD && rx_inic < base + 3; i++) @(negedge clock);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1;
        testes++;
        if ({saida_serial, ocupado} !== 2'b10) begin
            falhas++; $display("FAIL reset_mid got line=%b busy=%b want 1/0", saida_serial, ocupado);
        end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        limpa();
        espera_pronto(60*BD + 40, t);
        repeat (2) @(negedge clock);
        testes++;
        if (t < 0 || rx_q.size() != 6 || recebido() !== pacote(v)) begin
            falhas++;
            $display("FAIL reset_mid_packet got %h (n=%0d) want %h", recebido(), rx_q.size(), pacote(v));
        end
    endtask

    task automatic test_aleatorio();
        int t;
        int erros;
        logic [15:0] cur, nov;
        erros = 0;
        cur = {macro, micro, estado, resultado_macro, resultado_jogo};
        for (int n = 0; n < 100; n++) begin
            nov = 16'($urandom);
            if (nov == cur) nov = ~cur;
            limpa();
            aplica(nov);
            espera_pronto(60*BD + 40, t);
            repeat (2) @(negedge clock);
            testes++;
            if (t < 0 || rx_q.size() != 6 || recebido() !== pacote(nov) || max_gap() > 10*BD + 2) begin
                falhas++;
                erros++;
                if (erros <= 5)
                    $display("FAIL random_packet[%0d] got %h (n=%0d gap=%0d) want %h",
                             n, recebido(), rx_q.size(), max_gap(), pacote(nov));
            end
            cur = nov;
        end
        testes++;
        if (frame_err != 0 || shape_err != 0) begin
            falhas++; $display("FAIL line_framing got frame=%0d shape=%0d want 0/0", frame_err, shape_err);
        end
    endtask

    initial begin
        test_reset();
        test_campos();
        test_enviar();
        test_mudanca();
        test_reset_meio();
        test_aleatorio();
        $display("[TB] %0d tests run, %0d failed", testes, falhas);
        $finish;
    end

endmodule
